modsq_iter_ctrl: RTL and testbench
==================================

// Module: modsq_iter_ctrl
// PURPOSE
//  Parametrised successor to the fixed-depth squarer IO wrapper. Single clock domain, no MMCM.
//  Splits sq_in into coefficients and pipes them to an external free-running modular squarer core.
//  Starts the core, counts its per-iteration valid pulses up to a programmed iteration count T,
//  captures the T-th result, then quiesces the core. Supports abort and T==0 bypass.
// PARAMETERS
//  MOD_LEN            1024  modulus width in bits
//  WORD_LEN           16    nonredundant coefficient width
//  BIT_LEN            17    coefficient width on core bus
//  REDUNDANT_ELEMENTS 2     extra zeroed coefficients
//  NUM_ELEMENTS       MOD_LEN/WORD_LEN+REDUNDANT_ELEMENTS (derived)
//  IN_STAGES          3     input pipe depth, >=1
//  OUT_STAGES         3     output pipe depth, >=1; core_valid delayed identically
//  ITER_W             40    width of iteration count
//  CORE_RST_CYCLES    4     core_reset hold length after finish/abort, >=1
// PORTS
//  clk           in   1                        clock
//  reset_n       in   1                        asynchronous active-low reset
//  start         in   1                        request; sampled only in IDLE
//  iterations    in   ITER_W                   T, sampled with start
//  sq_in         in   MOD_LEN                  initial value, sampled with start
//  abort         in   1                        cancel run in LOAD/RUN
//  busy          out  1                        high in LOAD/RUN/QUIESCE
//  done          out  1                        1-cycle pulse, sq_out valid
//  aborted       out  1                        1-cycle pulse on abort acceptance
//  iter_count    out  ITER_W                   completed iterations this run
//  sq_out        out  NUM_ELEMENTS*2*WORD_LEN  result; coeff j at [j*2*WORD_LEN +: 2*WORD_LEN], zero-extended
//  core_start    out  1                        1-cycle start pulse to core
//  core_reset    out  1                        active-high sync reset to core
//  core_sq_in    out  NUM_ELEMENTS*BIT_LEN     coefficient bus to core (last input stage)
//  core_sq_out   in   NUM_ELEMENTS*BIT_LEN     core result bus
//  core_valid    in   1                        core pulses once per completed squaring
// BEHAVIOUR
//  Reset: all outputs, pipes and counters 0; state IDLE. core_reset=0 in reset.
//  Input split: stage0 coeff j = {0,sq_in[j*WORD_LEN+:WORD_LEN]}; redundant coeffs 0.
//    Loaded only on accepted start; pipes hold otherwise.
//  Output pipe: core_sq_out and core_valid both delayed OUT_STAGES cycles -> (ov_data, ov).
//  FSM:
//   IDLE: start & T!=0 -> latch T, load stage0, lcnt=IN_STAGES, iter_count=0, LOAD.
//         start & T==0 -> next cycle sq_out=split(sq_in) zero-extended, done=1; stay IDLE.
//   LOAD: lcnt-- each cycle; on the cycle lcnt reaches 0, core_start=1 (one cycle) -> RUN.
//         Data at core_sq_in is stable when core_start asserts.
//   RUN:  each ov pulse: iter_count++. When iter_count+1==T on an ov: sq_out<=ov_data,
//         done=1 next cycle, -> QUIESCE. ov in any other state ignored.
//   QUIESCE: core_reset=1 for exactly CORE_RST_CYCLES cycles; pipes' valid stages cleared;
//         -> IDLE. busy drops the cycle state returns to IDLE.
//  abort in LOAD/RUN: -> QUIESCE, aborted=1 next cycle, sq_out and iter_count held (no done).
//  abort and terminal ov same cycle: terminal ov wins (done, no aborted).
//  start while busy: ignored, no effect. abort in IDLE/QUIESCE: ignored.
//  iter_count saturates at T; counter never wraps (ov after done ignored).
//  reset_n low mid-run: immediate return to IDLE, all outputs 0; core_reset not asserted,
//    the core is held in reset by the system.
//  Latency T==0: done 1 cycle after start. T>0: core_start IN_STAGES+1 cycles after start;
//    done 1 cycle after T-th ov.
// TESTING
//  T=1, sq_in=0x...0003: core model returns 9 after 8 cycles -> core_start at start+4,
//    done once, sq_out coeff0=0x00000009, iter_count=1, core_reset high 4 cycles.
//  T=5, core valid every 8 cycles: exactly 5 ov counted, sq_out = 5th result, done single pulse.
//  T=0, sq_in low word 0xBEEF -> done next cycle, sq_out coeff0=0x0000BEEF, core_start never.
//  T=100, abort after 10 ov -> aborted pulse, no done, iter_count=10, core_reset 4 cycles.
//  Abort on same cycle as 3rd ov with T=3 -> done=1, aborted=0; start during busy ignored.
//  reset_n low mid-RUN -> all outputs 0 asynchronously; new start afterwards completes normally.

Source files
------------

// File: rtl/modsq_iter_ctrl.sv
// modsq_iter_ctrl: feeds an external free-running modular squarer,
// counts T iterations, captures the T-th result, then quiesces the core.
module modsq_iter_ctrl #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int BIT_LEN            = 17,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int IN_STAGES          = 3,
    parameter int OUT_STAGES         = 3,
    parameter int ITER_W             = 40,
    parameter int CORE_RST_CYCLES    = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [ITER_W-1:0]                   iterations,
    input  logic [MOD_LEN-1:0]                  sq_in,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic [ITER_W-1:0]                   iter_count,
    output logic [NUM_ELEMENTS*2*WORD_LEN-1:0]  sq_out,
    output logic                                core_start,
    output logic                                core_reset,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0]     core_sq_in,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]     core_sq_out,
    input  logic                                core_valid
);

    localparam int NWORDS = MOD_LEN / WORD_LEN;
    localparam int CBW    = NUM_ELEMENTS * BIT_LEN;
    localparam int OW     = NUM_ELEMENTS * 2 * WORD_LEN;
    localparam int LW     = $clog2(IN_STAGES + 1);
    localparam int QW     = $clog2(CORE_RST_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_QUIESCE = 2'd3;

    logic [1:0]            state;
    logic [ITER_W-1:0]     t_reg;
    logic [LW-1:0]         lcnt;
    logic [QW-1:0]         qcnt;
    logic [CBW-1:0]        in_pipe  [IN_STAGES];
    logic [CBW-1:0]        out_pipe [OUT_STAGES];
    logic [OUT_STAGES-1:0] ov_pipe;
    logic [CBW-1:0]        split_in;
    logic [OW-1:0]         split_ext;
    logic [OW-1:0]         ov_ext;
    logic [CBW-1:0]        ov_data;
    logic                  ov;
    logic                  ov_last;

    assign ov         = ov_pipe[OUT_STAGES-1];
    assign ov_data    = out_pipe[OUT_STAGES-1];
    assign core_sq_in = in_pipe[IN_STAGES-1];
    assign busy       = (state != S_IDLE);
    assign ov_last    = ov && ((iter_count + ITER_W'(1)) == t_reg);

    // Coefficient split of sq_in and zero-extension of core results
    always_comb begin
        split_in  = '0;
        split_ext = '0;
        ov_ext    = '0;
        for (int j = 0; j < NWORDS; j++) begin
            split_in[j*BIT_LEN +: BIT_LEN] =
                {{(BIT_LEN-WORD_LEN){1'b0}}, sq_in[j*WORD_LEN +: WORD_LEN]};
            split_ext[j*2*WORD_LEN +: 2*WORD_LEN] =
                {{WORD_LEN{1'b0}}, sq_in[j*WORD_LEN +: WORD_LEN]};
        end
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            ov_ext[j*2*WORD_LEN +: 2*WORD_LEN] =
                {{(2*WORD_LEN-BIT_LEN){1'b0}}, ov_data[j*BIT_LEN +: BIT_LEN]};
        end
    end

    // Input pipe: load on accepted start, advance only while loading
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IN_STAGES; i++) in_pipe[i] <= '0;
        end else if (state == S_IDLE && start && iterations != '0) begin
            in_pipe[0] <= split_in;
        end else if (state == S_LOAD) begin
            for (int i = 1; i < IN_STAGES; i++) in_pipe[i] <= in_pipe[i-1];
        end
    end

    // Output pipe: data and valid delayed alike; valids flushed in quiesce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUT_STAGES; i++) out_pipe[i] <= '0;
            ov_pipe <= '0;
        end else begin
            out_pipe[0] <= core_sq_out;
            for (int i = 1; i < OUT_STAGES; i++) out_pipe[i] <= out_pipe[i-1];
            if (state == S_QUIESCE) begin
                ov_pipe <= '0;
            end else begin
                ov_pipe[0] <= core_valid;
                for (int i = 1; i < OUT_STAGES; i++) ov_pipe[i] <= ov_pipe[i-1];
            end
        end
    end

    // Run control: load, start core, count iterations, capture, quiesce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            t_reg      <= '0;
            lcnt       <= '0;
            qcnt       <= '0;
            iter_count <= '0;
            sq_out     <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            core_start <= 1'b0;
            core_reset <= 1'b0;
        end else begin
            done       <= 1'b0;
            aborted    <= 1'b0;
            core_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        iter_count <= '0;
                        if (iterations == '0) begin
                            sq_out <= split_ext;
                            done   <= 1'b1;
                        end else begin
                            t_reg <= iterations;
                            lcnt  <= LW'(IN_STAGES);
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        aborted    <= 1'b1;
                        core_reset <= 1'b1;
                        qcnt       <= QW'(CORE_RST_CYCLES);
                        state      <= S_QUIESCE;
                    end else begin
                        lcnt <= lcnt - LW'(1);
                        if (lcnt == LW'(1)) begin
                            core_start <= 1'b1;
                            state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (ov_last) begin
                        sq_out     <= ov_ext;
                        iter_count <= iter_count + ITER_W'(1);
                        done       <= 1'b1;
                        core_reset <= 1'b1;
                        qcnt       <= QW'(CORE_RST_CYCLES);
                        state      <= S_QUIESCE;
                    end else if (abort) begin
                        aborted    <= 1'b1;
                        core_reset <= 1'b1;
                        qcnt       <= QW'(CORE_RST_CYCLES);
                        state      <= S_QUIESCE;
                    end else if (ov) begin
                        iter_count <= iter_count + ITER_W'(1);
                    end
                end
                S_QUIESCE: begin
                    qcnt <= qcnt - QW'(1);
                    if (qcnt == QW'(1)) begin
                        core_reset <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modsq_iter_ctrl.sv
// tb_modsq_iter_ctrl: randomized scenario bench with a behavioural
// squarer core and an iterated-square reference model.
module tb_modsq_iter_ctrl;

    localparam int MOD_LEN = 1024;
    localparam int WORD_LEN = 16;
    localparam int BIT_LEN = 17;
    localparam int RED = 2;
    localparam int NW = MOD_LEN / WORD_LEN;
    localparam int NUM = NW + RED;
    localparam int CBW = NUM * BIT_LEN;
    localparam int OW = NUM * 2 * WORD_LEN;
    localparam int ITER_W = 40;
    localparam int PERIOD = 8;
    localparam int OUTS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [ITER_W-1:0] iterations = '0;
    logic [MOD_LEN-1:0] sq_in = '0;
    logic busy, done, aborted, core_start, core_reset;
    logic core_valid;
    logic [ITER_W-1:0] iter_count;
    logic [OW-1:0] sq_out;
    logic [CBW-1:0] core_sq_in;
    logic [CBW-1:0] core_sq_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_cs, n_done, n_ab, n_cr, n_cv, n_busy;
    int cs_cyc, done_cyc, ab_cyc, cv_cyc, start_cyc;
    logic [OW-1:0] last_exp = '0;

    always #5 clk = ~clk;

    modsq_iter_ctrl #(
        .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN),
        .REDUNDANT_ELEMENTS(RED), .NUM_ELEMENTS(NUM),
        .IN_STAGES(3), .OUT_STAGES(OUTS), .ITER_W(ITER_W),
        .CORE_RST_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .iterations(iterations), .sq_in(sq_in), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted),
        .iter_count(iter_count), .sq_out(sq_out),
        .core_start(core_start), .core_reset(core_reset),
        .core_sq_in(core_sq_in), .core_sq_out(core_sq_out),
        .core_valid(core_valid)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: each PERIOD cycles, coeff j -> (x*x + j) mod 2^17
    longint acc [NUM];
    bit active = 1'b0;
    int ccnt = 0;
    logic [CBW-1:0] nxt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active = 1'b0;
            ccnt = 0;
            core_valid <= 1'b0;
            core_sq_out <= '0;
        end else begin
            core_valid <= 1'b0;
            if (core_reset) begin
                active = 1'b0;
            end else if (core_start) begin
                active = 1'b1;
                ccnt = 0;
                for (int j = 0; j < NUM; j++)
                    acc[j] = longint'(core_sq_in[j*BIT_LEN +: BIT_LEN]);
            end else if (active) begin
                ccnt++;
                if (ccnt == PERIOD) begin
                    ccnt = 0;
                    for (int j = 0; j < NUM; j++) begin
                        acc[j] = (acc[j] * acc[j] + j) % 131072;
                        nxt[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(acc[j]);
                    end
                    core_sq_out <= nxt;
                    core_valid <= 1'b1;
                end
            end
        end
    end

    // Event monitor sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_start) begin n_cs++; cs_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (aborted) begin n_ab++; ab_cyc = cyc; end
            if (core_reset) n_cr++;
            if (core_valid) begin n_cv++; cv_cyc = cyc; end
            if (busy) n_busy++;
        end
    end

    function automatic logic [MOD_LEN-1:0] rand_vec();
        logic [MOD_LEN-1:0] v;
        for (int i = 0; i < MOD_LEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: T iterations of per-coefficient squaring, zero-extended
    function automatic logic [OW-1:0] ref_sq(input logic [MOD_LEN-1:0] v,
                                             input int t);
        longint c [NUM];
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < NUM; j++)
            c[j] = (j < NW) ? longint'(v[j*WORD_LEN +: WORD_LEN]) : 0;
        for (int k = 0; k < t; k++)
            for (int j = 0; j < NUM; j++) c[j] = (c[j] * c[j] + j) % 131072;
        for (int j = 0; j < NUM; j++) r[j*32 +: 32] = 32'(c[j]);
        return r;
    endfunction

    function automatic int first_diff(input logic [OW-1:0] a,
                                      input logic [OW-1:0] b);
        for (int j = 0; j < NUM; j++)
            if (a[j*32 +: 32] !== b[j*32 +: 32]) return j;
        return 0;
    endfunction

    task automatic do_start(input logic [ITER_W-1:0] t,
                            input logic [MOD_LEN-1:0] v);
        @(negedge clk);
        n_cs = 0; n_done = 0; n_ab = 0; n_cr = 0; n_cv = 0; n_busy = 0;
        cs_cyc = -1; done_cyc = -1; ab_cyc = -1; cv_cyc = -1;
        start = 1'b1;
        iterations = t;
        sq_in = v;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        iterations = ITER_W'($urandom);
        sq_in = rand_vec();
    endtask

    task automatic wait_end(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            #1;
            if ((n_done + n_ab) > 0 && !busy) break;
            @(negedge clk);
        end
        if (i >= budget) begin
            tests++; fails++;
            $display("FAIL %s_timeout got busy=%0b done=%0d exp finish in %0d",
                     nm, busy, n_done, budget);
        end
    endtask

    task automatic wait_cv(input int n, input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_cv >= n) break;
        end
        if (i >= budget) begin
            tests++; fails++;
            $display("FAIL %s_cv_timeout got %0d exp %0d", nm, n_cv, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, aborted, core_start, core_reset} !== 5'b0) begin
            fails++;
            $display("FAIL rst_ctrl got %b exp 00000",
                     {busy, done, aborted, core_start, core_reset});
        end
        tests++;
        if (iter_count !== '0 || sq_out !== '0) begin
            fails++;
            $display("FAIL rst_out got ic=%0d sq0=%h exp 0 0",
                     iter_count, sq_out[31:0]);
        end
        tests++;
        if (core_sq_in !== '0) begin
            fails++;
            $display("FAIL rst_core_sq_in got %h exp 0", core_sq_in[31:0]);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_t1();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        v = rand_vec();
        v[15:0] = 16'h0003;
        e = ref_sq(v, 1);
        do_start(40'd1, v);
        wait_end(200, "t1");
        tests++;
        if (cs_cyc - start_cyc !== 4) begin
            fails++;
            $display("FAIL t1_core_start_lat got %0d exp 4", cs_cyc - start_cyc);
        end
        tests++;
        if (n_cs !== 1 || n_done !== 1 || n_ab !== 0) begin
            fails++;
            $display("FAIL t1_pulses got cs=%0d done=%0d ab=%0d exp 1 1 0",
                     n_cs, n_done, n_ab);
        end
        tests++;
        if (sq_out[31:0] !== 32'h0000_0009) begin
            fails++;
            $display("FAIL t1_coeff0 got %h exp 00000009", sq_out[31:0]);
        end
        tests++;
        if (sq_out !== e) begin
            fails++;
            $display("FAIL t1_sq_out coeff %0d got %h exp %h",
                     first_diff(sq_out, e),
                     sq_out[first_diff(sq_out, e)*32 +: 32],
                     e[first_diff(sq_out, e)*32 +: 32]);
        end
        tests++;
        if (iter_count !== 40'd1) begin
            fails++;
            $display("FAIL t1_iter_count got %0d exp 1", iter_count);
        end
        tests++;
        if (n_cr !== 4) begin
            fails++;
            $display("FAIL t1_core_reset_len got %0d exp 4", n_cr);
        end
        last_exp = e;
    endtask

    task automatic test_t5();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        v = rand_vec();
        e = ref_sq(v, 5);
        do_start(40'd5, v);
        wait_end(300, "t5");
        tests++;
        if (iter_count !== 40'd5) begin
            fails++;
            $display("FAIL t5_iter_count got %0d exp 5", iter_count);
        end
        tests++;
        if (sq_out !== e) begin
            fails++;
            $display("FAIL t5_sq_out coeff %0d got %h exp %h",
                     first_diff(sq_out, e),
                     sq_out[first_diff(sq_out, e)*32 +: 32],
                     e[first_diff(sq_out, e)*32 +: 32]);
        end
        tests++;
        if (n_done !== 1 || done_cyc !== cv_cyc + OUTS + 1) begin
            fails++;
            $display("FAIL t5_done got n=%0d at %0d exp 1 at %0d",
                     n_done, done_cyc, cv_cyc + OUTS + 1);
        end
        last_exp = e;
    endtask

    task automatic test_t0();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        v = rand_vec();
        v[15:0] = 16'hBEEF;
        e = ref_sq(v, 0);
        do_start(40'd0, v);
        wait_end(20, "t0");
        repeat (3) @(negedge clk);
        tests++;
        if (n_done !== 1 || done_cyc !== start_cyc + 1) begin
            fails++;
            $display("FAIL t0_done got n=%0d at +%0d exp 1 at +1",
                     n_done, done_cyc - start_cyc);
        end
        tests++;
        if (sq_out[31:0] !== 32'h0000_BEEF || sq_out !== e) begin
            fails++;
            $display("FAIL t0_sq_out coeff %0d got %h exp %h",
                     first_diff(sq_out, e),
                     sq_out[first_diff(sq_out, e)*32 +: 32],
                     e[first_diff(sq_out, e)*32 +: 32]);
        end
        tests++;
        if (n_cs !== 0 || n_cr !== 0 || n_busy !== 0) begin
            fails++;
            $display("FAIL t0_no_core got cs=%0d cr=%0d busy=%0d exp 0 0 0",
                     n_cs, n_cr, n_busy);
        end
        last_exp = e;
    endtask

    task automatic test_abort();
        int acyc;
        do_start(40'd100, rand_vec());
        wait_cv(10, 300, "abort");
        repeat (5) @(negedge clk);
        abort = 1'b1;
        acyc = cyc;
        @(negedge clk);
        abort = 1'b0;
        wait_end(50, "abort");
        tests++;
        if (n_ab !== 1 || n_done !== 0 || ab_cyc !== acyc + 1) begin
            fails++;
            $display("FAIL abort_pulses got ab=%0d done=%0d at +%0d exp 1 0 +1",
                     n_ab, n_done, ab_cyc - acyc);
        end
        tests++;
        if (iter_count !== 40'd10) begin
            fails++;
            $display("FAIL abort_iter_count got %0d exp 10", iter_count);
        end
        tests++;
        if (sq_out !== last_exp) begin
            fails++;
            $display("FAIL abort_sq_held got %h exp %h",
                     sq_out[31:0], last_exp[31:0]);
        end
        tests++;
        if (n_cr !== 4) begin
            fails++;
            $display("FAIL abort_core_reset_len got %0d exp 4", n_cr);
        end
    endtask

    task automatic test_abort_terminal();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        v = rand_vec();
        e = ref_sq(v, 3);
        do_start(40'd3, v);
        start = 1'b1;
        iterations = 40'd1;
        @(negedge clk);
        start = 1'b0;
        wait_cv(1, 100, "abt3");
        start = 1'b1;
        iterations = 40'd2;
        sq_in = rand_vec();
        @(negedge clk);
        start = 1'b0;
        wait_cv(3, 100, "abt3");
        repeat (OUTS) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end(50, "abt3");
        tests++;
        if (n_done !== 1 || n_ab !== 0 || n_cs !== 1) begin
            fails++;
            $display("FAIL abt3_pulses got done=%0d ab=%0d cs=%0d exp 1 0 1",
                     n_done, n_ab, n_cs);
        end
        tests++;
        if (iter_count !== 40'd3 || sq_out !== e) begin
            fails++;
            $display("FAIL abt3_result got ic=%0d c0=%h exp 3 %h",
                     iter_count, sq_out[31:0], e[31:0]);
        end
        last_exp = e;
    endtask

    task automatic test_async_reset();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        do_start(40'd50, rand_vec());
        wait_cv(2, 100, "arst");
        repeat (OUTS + 1) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, aborted, core_start, core_reset} !== 5'b0 ||
            iter_count !== '0 || sq_out !== '0 || core_sq_in !== '0) begin
            fails++;
            $display("FAIL arst_outputs got busy=%0b ic=%0d sq0=%h exp all 0",
                     busy, iter_count, sq_out[31:0]);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        v = rand_vec();
        e = ref_sq(v, 2);
        do_start(40'd2, v);
        wait_end(200, "arst");
        tests++;
        if (sq_out !== e || iter_count !== 40'd2 || n_done !== 1) begin
            fails++;
            $display("FAIL arst_rerun got ic=%0d c0=%h done=%0d exp 2 %h 1",
                     iter_count, sq_out[31:0], n_done, e[31:0]);
        end
        last_exp = e;
    endtask

    task automatic test_back_to_back();
        logic [MOD_LEN-1:0] v;
        logic [OW-1:0] e;
        int t;
        for (int r = 0; r < 5; r++) begin
            t = $urandom_range(0, 6);
            v = rand_vec();
            e = ref_sq(v, t);
            do_start(ITER_W'(t), v);
            wait_end(t * PERIOD + 80, "b2b");
            tests++;
            if (sq_out !== e || n_done !== 1 ||
                (t != 0 && iter_count !== ITER_W'(t))) begin
                fails++;
                $display("FAIL b2b_run%0d T=%0d got ic=%0d c0=%h done=%0d exp %h",
                         r, t, iter_count, sq_out[31:0], n_done, e[31:0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_t1();
        test_t5();
        test_t0();
        test_abort();
        test_abort_terminal();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
